// File: rtl/mouse_click_decoder.sv
// ---------------------------------------------------------------------------
// mouse_click_decoder
//
// Purpose:
//   Classifies left-button gestures from the registered mouse-position stage
//   (pclk domain) into short click, long press and drag-end events. Events are
//   presented one at a time on a single-entry valid/ready slot. A live drag
//   indicator and signed drag offsets feed the cursor-overlay logic.
//
// Optional feature:
//   MOUSE_CLICK_DOUBLE_EN - when defined, a short click whose press lands
//   within DBL_WINDOW cycles after a previous short click is reported as a
//   double click (type 11). Undefined: no window logic, type 11 never occurs.
//
// Ports:
//   pclk           in   1   pixel clock, rising edge
//   rst            in   1   synchronous active-high reset
//   xpos_in        in  12   registered cursor X
//   ypos_in        in  12   registered cursor Y
//   mouse_left_in  in   1   registered left button, 1 = pressed
//   click_valid    out  1   event slot holds an event
//   click_ready    in   1   consumer accepts the event when high with valid
//   click_x        out 12   event X
//   click_y        out 12   event Y
//   click_type     out  2   00 short, 01 long, 10 drag end, 11 double
//   drag_active    out  1   high while dragging
//   drag_dx        out 13   signed X offset from the press point
//   drag_dy        out 13   signed Y offset from the press point
//   overflow       out  1   sticky: an event was dropped (cleared by rst only)
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | button up, waiting for a press
// PRESS | button down, anchor latched, timing the hold and watching motion
// HOLD  | long press already reported, waiting for release (no event)
// DRAG  | motion exceeded threshold, tracking offsets until release
// ---------------------------------------------------------------------------
module mouse_click_decoder #(
    parameter int DRAG_THRESH       = 4,
    parameter int LONG_PRESS_CYCLES = 20000000,
    parameter int CNT_W             = 25,
    parameter int DBL_WINDOW        = 12000000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        mouse_left_in,
    output logic        click_valid,
    input  logic        click_ready,
    output logic [11:0] click_x,
    output logic [11:0] click_y,
    output logic [1:0]  click_type,
    output logic        drag_active,
    output logic [12:0] drag_dx,
    output logic [12:0] drag_dy,
    output logic        overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAG  = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_SHORT  = 2'b00;
    localparam logic [1:0] TYPE_LONG   = 2'b01;
    localparam logic [1:0] TYPE_DRAG   = 2'b10;
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [12:0] THRESH13     = 13'(DRAG_THRESH);

    state_t            r_state;
    logic              r_prev;
    logic [11:0]       r_ax;
    logic [11:0]       r_ay;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic [11:0]       r_click_x;
    logic [11:0]       r_click_y;
    logic [1:0]        r_click_type;
    logic              r_drag_active;
    logic [12:0]       r_dx;
    logic [12:0]       r_dy;
    logic              r_overflow;

    logic              w_press;
    logic              w_release;
    logic [12:0]       w_dx;
    logic [12:0]       w_dy;
    logic [12:0]       w_adx;
    logic [12:0]       w_ady;
    logic              w_moved;
    logic              w_to_drag;
    logic              w_to_long;
    logic              w_short;
    logic [1:0]        w_short_type;
    logic              w_ev;
    logic [1:0]        w_ev_type;
    logic [11:0]       w_ev_x;
    logic [11:0]       w_ev_y;

`ifdef MOUSE_CLICK_DOUBLE_EN
    localparam int            WIN_W    = $clog2(DBL_WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(DBL_WINDOW);

    logic [WIN_W-1:0] r_win_cnt;
    logic             r_dbl_armed;

    assign w_short_type = r_dbl_armed ? 2'b11 : TYPE_SHORT;
`else
    logic w_unused_dbl;

    assign w_unused_dbl = (DBL_WINDOW > 0);
    assign w_short_type = TYPE_SHORT;
`endif

    assign w_press   = mouse_left_in & ~r_prev;
    assign w_release = ~mouse_left_in & r_prev;

    // 13-bit differences cannot wrap for 12-bit unsigned operands.
    assign w_dx  = {1'b0, xpos_in} - {1'b0, r_ax};
    assign w_dy  = {1'b0, ypos_in} - {1'b0, r_ay};
    assign w_adx = w_dx[12] ? (13'd0 - w_dx) : w_dx;
    assign w_ady = w_dy[12] ? (13'd0 - w_dy) : w_dy;
    assign w_moved = (w_adx > THRESH13) || (w_ady > THRESH13);

    // Priority inside PRESS: release, then drag, then long press.
    assign w_short   = (r_state == ST_PRESS) && w_release;
    assign w_to_drag = (r_state == ST_PRESS) && !w_release && w_moved;
    assign w_to_long = (r_state == ST_PRESS) && !w_release && !w_moved
                       && (r_cnt == LP_LAST);

    always_comb begin
        w_ev      = 1'b0;
        w_ev_type = TYPE_SHORT;
        w_ev_x    = r_ax;
        w_ev_y    = r_ay;
        if (w_short) begin
            w_ev      = 1'b1;
            w_ev_type = w_short_type;
        end else if (w_to_long) begin
            w_ev      = 1'b1;
            w_ev_type = TYPE_LONG;
        end else if ((r_state == ST_DRAG) && w_release) begin
            w_ev      = 1'b1;
            w_ev_type = TYPE_DRAG;
            w_ev_x    = xpos_in;
            w_ev_y    = ypos_in;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_prev        <= 1'b1;  // a button held through reset is not a press
            r_ax          <= '0;
            r_ay          <= '0;
            r_cnt         <= '0;
            r_valid       <= 1'b0;
            r_click_x     <= '0;
            r_click_y     <= '0;
            r_click_type  <= TYPE_SHORT;
            r_drag_active <= 1'b0;
            r_dx          <= '0;
            r_dy          <= '0;
            r_overflow    <= 1'b0;
`ifdef MOUSE_CLICK_DOUBLE_EN
            r_win_cnt     <= '0;
            r_dbl_armed   <= 1'b0;
`endif
        end else begin
            r_prev <= mouse_left_in;

            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_ax    <= xpos_in;
                        r_ay    <= ypos_in;
                        r_cnt   <= '0;
                        r_state <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_release) begin
                        r_state <= ST_IDLE;
                    end else if (w_moved) begin
                        r_state       <= ST_DRAG;
                        r_drag_active <= 1'b1;
                        r_dx          <= w_dx;
                        r_dy          <= w_dy;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAG: begin
                    r_dx <= w_dx;
                    r_dy <= w_dy;
                    if (w_release) begin
                        r_drag_active <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Single-entry slot; a same-edge handshake makes room for a new event.
            if (w_ev) begin
                if (!r_valid || click_ready) begin
                    r_valid      <= 1'b1;
                    r_click_x    <= w_ev_x;
                    r_click_y    <= w_ev_y;
                    r_click_type <= w_ev_type;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_valid && click_ready) begin
                r_valid <= 1'b0;
            end

`ifdef MOUSE_CLICK_DOUBLE_EN
            if (r_win_cnt != '0) begin
                r_win_cnt <= r_win_cnt - WIN_W'(1);
            end
            if ((r_state == ST_IDLE) && w_press) begin
                r_dbl_armed <= (r_win_cnt != '0);
            end
            if (w_to_drag || w_to_long) begin
                r_win_cnt   <= '0;
                r_dbl_armed <= 1'b0;
            end
            // A plain short click opens a window; a double click closes it.
            if (w_short) begin
                r_dbl_armed <= 1'b0;
                r_win_cnt   <= r_dbl_armed ? '0 : WIN_LOAD;
            end
`endif
        end
    end

    assign click_valid = r_valid;
    assign click_x     = r_click_x;
    assign click_y     = r_click_y;
    assign click_type  = r_click_type;
    assign drag_active = r_drag_active;
    assign drag_dx     = r_dx;
    assign drag_dy     = r_dy;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_mouse_click_decoder.sv
module tb_mouse_click_decoder;

    localparam int LP = 100;
    localparam int DT = 4;
    localparam int DW = 50;
`ifdef MOUSE_CLICK_DOUBLE_EN
    localparam logic [1:0] DBL_T = 2'b11;
`else
    localparam logic [1:0] DBL_T = 2'b00;
`endif

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] xpos_in;
    logic [11:0] ypos_in;
    logic        mouse_left_in;
    logic        click_valid;
    logic        click_ready;
    logic [11:0] click_x;
    logic [11:0] click_y;
    logic [1:0]  click_type;
    logic        drag_active;
    logic [12:0] drag_dx;
    logic [12:0] drag_dy;
    logic        overflow;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  t;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    mouse_click_decoder #(
        .DRAG_THRESH      (DT),
        .LONG_PRESS_CYCLES(LP),
        .CNT_W            (25),
        .DBL_WINDOW       (DW)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .xpos_in      (xpos_in),
        .ypos_in      (ypos_in),
        .mouse_left_in(mouse_left_in),
        .click_valid  (click_valid),
        .click_ready  (click_ready),
        .click_x      (click_x),
        .click_y      (click_y),
        .click_type   (click_type),
        .drag_active  (drag_active),
        .drag_dx      (drag_dx),
        .drag_dy      (drag_dy),
        .overflow     (overflow)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic push(input logic [11:0] x, input logic [11:0] y, input logic [1:0] t);
        ev_t e;
        e.x = x;
        e.y = y;
        e.t = t;
        q.push_back(e);
    endtask

    // Stationary press/release; the expected event (if any) is queued before
    // the release edge so the monitor can match it.
    task automatic click(input logic [11:0] x, input logic [11:0] y, input int hold,
                         input bit expect_ev, input logic [1:0] t);
        xpos_in = x;
        ypos_in = y;
        mouse_left_in = 1'b1;
        tick(1);
        tick(hold);
        mouse_left_in = 1'b0;
        if (expect_ev) push(x, y, t);
        tick(1);
    endtask

    // Scoreboard monitor: every presented event is compared against the head
    // of the queue; the head is popped only on an accepting handshake.
    always @(negedge pclk) begin
        if (!rst && click_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: got x=%0d y=%0d type=%0d, required no event",
                         click_x, click_y, click_type);
            end else begin
                chk("ev_x", 32'(click_x), 32'(q[0].x));
                chk("ev_y", 32'(click_y), 32'(q[0].y));
                chk("ev_type", 32'(click_type), 32'(q[0].t));
                if (click_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        mouse_left_in = 1'b0;
        xpos_in = '0;
        ypos_in = '0;
        click_ready = 1'b1;
        tick(3);
        chk("rst_valid", 32'(click_valid), 0);
        chk("rst_x", 32'(click_x), 0);
        chk("rst_y", 32'(click_y), 0);
        chk("rst_type", 32'(click_type), 0);
        chk("rst_drag", 32'(drag_active), 0);
        chk("rst_dx", 32'(drag_dx), 0);
        chk("rst_dy", 32'(drag_dy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        tick(2);

        // Short click, small motion before release, event at press point.
        xpos_in = 12'd100; ypos_in = 12'd200; mouse_left_in = 1'b1;
        tick(1);
        tick(10);
        chk("short_no_drag", 32'(drag_active), 0);
        xpos_in = 12'd102; ypos_in = 12'd201; mouse_left_in = 1'b0;
        push(12'd100, 12'd200, 2'b00);
        tick(1);
        chk("short_latency", 32'(click_valid), 1);
        chk("short_drag_low", 32'(drag_active), 0);
        tick(60);

        // Long press: event exactly LP cycles after press detection.
        xpos_in = 12'd50; ypos_in = 12'd50; mouse_left_in = 1'b1;
        tick(1);
        tick(LP - 1);
        chk("long_early", 32'(click_valid), 0);
        push(12'd50, 12'd50, 2'b01);
        tick(1);
        chk("long_on_time", 32'(click_valid), 1);
        tick(49);
        mouse_left_in = 1'b0;
        tick(4);
        chk("long_release_quiet", 32'(click_valid), 0);
        tick(60);

        // Drag: dx=+5 crosses threshold, then +20/-20, end at release position.
        xpos_in = 12'd300; ypos_in = 12'd300; mouse_left_in = 1'b1;
        tick(1);
        xpos_in = 12'd305; ypos_in = 12'd290;
        tick(1);
        chk("drag_rise", 32'(drag_active), 1);
        chk("drag_dx5", 32'(drag_dx), 5);
        xpos_in = 12'd320; ypos_in = 12'd280;
        tick(1);
        chk("drag_dx20", 32'(drag_dx), 20);
        chk("drag_dym20", 32'(drag_dy), 32'(13'h1FEC));  // -20 in 13 bits
        mouse_left_in = 1'b0;
        push(12'd320, 12'd280, 2'b10);
        tick(1);
        chk("drag_fall", 32'(drag_active), 0);
        chk("drag_end_valid", 32'(click_valid), 1);
        chk("drag_dx_hold", 32'(drag_dx), 20);
        tick(60);

        // Motion of exactly DRAG_THRESH on both axes is not a drag.
        xpos_in = 12'd200; ypos_in = 12'd200; mouse_left_in = 1'b1;
        tick(1);
        xpos_in = 12'd204; ypos_in = 12'd196;
        tick(5);
        chk("thresh_no_drag", 32'(drag_active), 0);
        mouse_left_in = 1'b0;
        push(12'd200, 12'd200, 2'b00);
        tick(1);
        tick(60);

        // Back-pressure: first event held, second dropped, overflow sticky.
        click_ready = 1'b0;
        click(12'd10, 12'd20, 2, 1'b1, 2'b00);
        tick(2);
        click(12'd30, 12'd40, 2, 1'b0, 2'b00);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_held_x", 32'(click_x), 10);
        chk("ovf_held_valid", 32'(click_valid), 1);
        click_ready = 1'b1;
        tick(1);
        chk("accept_drop", 32'(click_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        tick(60);

        // New event on the same edge as a handshake replaces the slot.
        click_ready = 1'b0;
        click(12'd60, 12'd70, 2, 1'b1, 2'b00);
        tick(2);
        xpos_in = 12'd80; ypos_in = 12'd90; mouse_left_in = 1'b1;
        tick(3);
        mouse_left_in = 1'b0;
        click_ready = 1'b1;
        push(12'd80, 12'd90, DBL_T);
        tick(1);
        chk("same_edge_valid", 32'(click_valid), 1);
        chk("same_edge_x", 32'(click_x), 80);
        tick(2);
        chk("same_edge_drain", 32'(click_valid), 0);
        tick(60);

        // Button held through reset release produces nothing; FSM is idle.
        mouse_left_in = 1'b1;
        rst = 1'b1;
        q.delete();
        tick(2);
        rst = 1'b0;
        tick(3);
        mouse_left_in = 1'b0;
        tick(3);
        chk("held_rst_quiet", 32'(click_valid), 0);
        chk("held_rst_drag", 32'(drag_active), 0);
        click(12'd7, 12'd8, 2, 1'b1, 2'b00);
        tick(2);
        chk("post_rst_drain", 32'(click_valid), 0);

        // Reset in the middle of a drag aborts it.
        xpos_in = 12'd500; ypos_in = 12'd500; mouse_left_in = 1'b1;
        tick(1);
        xpos_in = 12'd520;
        tick(1);
        chk("mid_drag_active", 32'(drag_active), 1);
        rst = 1'b1;
        q.delete();
        tick(1);
        chk("mid_rst_drag", 32'(drag_active), 0);
        chk("mid_rst_valid", 32'(click_valid), 0);
        chk("mid_rst_dx", 32'(drag_dx), 0);
        rst = 1'b0;
        mouse_left_in = 1'b0;
        tick(3);
        chk("mid_rst_quiet", 32'(click_valid), 0);
        tick(60);

        // Click pairs 30 and 80 cycles apart (double only with the feature).
        click(12'd1, 12'd1, 2, 1'b1, 2'b00);
        tick(25);
        click(12'd2, 12'd2, 2, 1'b1, DBL_T);
        tick(100);
        click(12'd3, 12'd3, 2, 1'b1, 2'b00);
        tick(75);
        click(12'd4, 12'd4, 2, 1'b1, 2'b00);
        tick(5);

        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mouse_click_decoder.md
Name: mouse_click_decoder

Overview:
- Downstream of the registered mouse-position stage in the pclk (40 MHz) domain.
- Consumes the registered xpos/ypos/left-button, classifies gestures (short click, long press, drag) and presents one event at a time on a valid/ready port.
- Also provides a live drag indicator and drag offsets for the channel-selection / cursor overlay logic.

Parameters:
- DRAG_THRESH, 4, pixel distance on either axis (strictly greater than) that turns a press into a drag.
- LONG_PRESS_CYCLES, 20000000, pclk cycles of stationary hold that make a long press (0.5 s).
- CNT_W, 25, hold-counter width; must hold LONG_PRESS_CYCLES.
- DBL_WINDOW, 12000000, double-click window in cycles; used only with the optional feature.

Ports:
- pclk  in  1  pixel clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- xpos_in  in  12  registered cursor X.
- ypos_in  in  12  registered cursor Y.
- mouse_left_in  in  1  registered left button, 1 = pressed.
- click_valid  out  1  event slot holds an event.
- click_ready  in  1  consumer accepts event when high together with click_valid.
- click_x  out  12  event X.
- click_y  out  12  event Y.
- click_type  out  2  event type: 00 short, 01 long, 10 drag end, 11 double (optional feature only).
- drag_active  out  1  high while in DRAG.
- drag_dx  out  13  signed X offset from the press point.
- drag_dy  out  13  signed Y offset from the press point.
- overflow  out  1  sticky flag: an event was dropped.

Behaviour:
- Reset:
  - click_valid=0, click_x/y=0, click_type=00, drag_active=0, drag_dx/dy=0, overflow=0, state=IDLE, counter=0.
  - Internal previous-button register is loaded with 1, so a button held through reset release generates no press.
  - Reset mid-operation discards any pending event and aborts any gesture.
- Edges: press = mouse_left_in=1 and prev=0; release = mouse_left_in=0 and prev=1. prev updates every cycle.
- States:
  - IDLE: on press, latch anchor (ax,ay) = (xpos_in,ypos_in), counter=0, go to PRESS. A release seen in IDLE is ignored.
  - PRESS:
    - Counter increments each cycle.
    - Priority: release > drag > long.
    - Release: emit short at (ax,ay), go to IDLE.
    - Else if |xpos_in-ax|>DRAG_THRESH or |ypos_in-ay|>DRAG_THRESH: go to DRAG, drag_active=1 from the next cycle.
    - Else if counter==LONG_PRESS_CYCLES-1: emit long at (ax,ay), go to HOLD.
  - HOLD: motion is ignored; on release go to IDLE with no event.
  - DRAG:
    - Each cycle drag_dx = xpos_in-ax and drag_dy = ypos_in-ay, as 13-bit two's complement, registered.
    - On release: emit drag end at the release-cycle (xpos_in,ypos_in), drag_active=0, go to IDLE.
    - drag_dx/dy hold their last value after the drag ends.
- Absolute differences are computed in 13 bits; no wrap is possible on 12-bit inputs.
- Event latency: click_valid is high on the cycle after the edge where the triggering input is sampled (1 cycle).
- Event slot (single entry):
  - click_valid && click_ready: slot frees on that edge.
  - New event while the slot is occupied and click_ready=0: the event is dropped, overflow is set, and the slot is unchanged.
  - New event on the same edge as a handshake: the new event loads and click_valid stays 1.
  - click_x/y/type remain stable while click_valid=1 and not accepted.
- overflow clears only on rst.

Optional Feature:
- Macro: MOUSE_CLICK_DOUBLE_EN.
- Defined:
  - After a short event, a window counter runs for DBL_WINDOW cycles.
  - A following gesture that starts (press) inside the window and ends as a short event is reported as type 11 instead of 00; the window then closes.
  - A long press or drag closes the window.
- Undefined: no window logic; type 11 is never produced.

Test Plan (LONG_PRESS_CYCLES=100, DRAG_THRESH=4, click_ready=1 unless stated):
- Press at (100,200), hold 10 cycles, release at (102,201) -> one cycle after the release sample: click_valid=1, type 00, (100,200); drag_active stays 0.
- Press at (50,50), hold stationary 150 cycles -> type 01 at (50,50) exactly 100 cycles after press detection; no event on release.
- Press at (300,300), move to (305,290), release at (320,280) -> drag_active rises after x=305 is sampled; drag_dx=+20, drag_dy=-20 before release; type 10 at (320,280).
- click_ready=0, two short clicks -> first event held stable, second dropped, overflow=1; raise click_ready -> valid drops after one accept cycle, overflow stays 1.
- Button held through rst deassert, then released -> no event, state IDLE; reset asserted mid-DRAG -> drag_active=0 and click_valid=0 the next cycle.
- With MOUSE_CLICK_DOUBLE_EN and DBL_WINDOW=50: two short clicks 30 cycles apart -> types 00 then 11; repeat 80 cycles apart -> 00 then 00.
